// File: rtl/matrix_scan_ctrl.sv
// Column-scan controller for a 5x7 LED matrix with double-buffered frame store.
// Optional macro SCAN_BRIGHTNESS_EN adds a 3-bit brightness input that trims the lit part of DRIVE.
module matrix_scan_ctrl #(
  parameter int N_COLS    = 5,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_col,
  input  logic [6:0] wr_data,
  input  logic       swap_req,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [2:0] brightness,
`endif
  output logic       swap_ack,
  output logic [2:0] col_sel,
  output logic       col_en,
  output logic [6:0] row_n,
  output logic       frame_start
);

  localparam int TMAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [2:0] LAST_COL = 3'(N_COLS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    col_nxt;
  logic          col_en_nxt;
  logic [6:0]    row_nxt;
  logic          frame_nxt;
  logic          pending, pending_nxt;
  logic          swap_go;
  logic          blank_end, drive_end;
  logic          wr_ok;

  // Sized to the full 3-bit column space; entries at or above N_COLS are never written.
  logic [6:0] front [8];
  logic [6:0] back  [8];

`ifdef SCAN_BRIGHTNESS_EN
  logic [2:0] bright_q, bright_sel;

  function automatic int duty_limit(input logic [2:0] b);
    return ((int'(b) + 1) * CLK_DIV) / 8;
  endfunction
`endif

  assign blank_end = (timer == TW'(BLANK_CYC - 1));
  assign drive_end = (timer == TW'(CLK_DIV - 1));
  assign wr_ok     = wr_en && ({1'b0, wr_col} < 4'(N_COLS));

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + TW'(1);
    col_nxt   = col_sel;
    if (!enable) begin
      state_nxt = IDLE;
      timer_nxt = '0;
      col_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          timer_nxt = '0;
          col_nxt   = '0;
        end
        BLANK: begin
          if (blank_end) begin
            state_nxt = DRIVE;
            timer_nxt = '0;
          end
        end
        DRIVE: begin
          if (drive_end) begin
            state_nxt = BLANK;
            timer_nxt = '0;
            col_nxt   = (col_sel == LAST_COL) ? 3'd0 : col_sel + 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
          col_nxt   = '0;
        end
      endcase
    end

    // Swap only while the display is dark: at the frame boundary or while idle.
    swap_go = (pending || swap_req) &&
              ((state == IDLE) ||
               (enable && state == DRIVE && drive_end && col_sel == LAST_COL));
    pending_nxt = swap_go ? 1'b0 : (pending || swap_req);

    frame_nxt = enable && (state == BLANK) && blank_end && (col_sel == 3'd0);

`ifdef SCAN_BRIGHTNESS_EN
    bright_sel = ((state_nxt == DRIVE) && (state != DRIVE)) ? brightness : bright_q;
    col_en_nxt = (state_nxt == DRIVE) && (int'(timer_nxt) < duty_limit(bright_sel));
`else
    col_en_nxt = (state_nxt == DRIVE);
`endif
    row_nxt = col_en_nxt ? ~front[col_nxt] : 7'h7F;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      col_sel     <= '0;
      col_en      <= 1'b0;
      row_n       <= 7'h7F;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      pending     <= 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
      bright_q    <= '0;
`endif
      for (int i = 0; i < 8; i++) begin
        front[i] <= '0;
        back[i]  <= '0;
      end
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      col_sel     <= col_nxt;
      col_en      <= col_en_nxt;
      row_n       <= row_nxt;
      frame_start <= frame_nxt;
      swap_ack    <= swap_go;
      pending     <= pending_nxt;
`ifdef SCAN_BRIGHTNESS_EN
      bright_q    <= bright_sel;
`endif
      // Front takes the pre-write back contents when a write lands on the swap edge.
      if (swap_go) begin
        for (int i = 0; i < 8; i++) front[i] <= back[i];
      end
      if (wr_ok) back[wr_col] <= wr_data;
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with CLK_DIV=4, BLANK_CYC=2 (30-cycle frame).
module tb_matrix_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_col;
  logic [6:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic [2:0] col_sel;
  logic       col_en;
  logic [6:0] row_n;
  logic       frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  matrix_scan_ctrl #(.N_COLS(5), .CLK_DIV(4), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness (3'd7),
`endif
    .swap_ack   (swap_ack),
    .col_sel    (col_sel),
    .col_en     (col_en),
    .row_n      (row_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_drive(input logic [2:0] c, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (col_sel == c && col_en) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_reach"}, found, 1);
  endtask

  task automatic wait_ack(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (swap_ack) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_ack"}, found, 1);
  endtask

  task automatic write(input logic [2:0] c, input logic [6:0] d);
    wr_en = 1'b1; wr_col = c; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  initial begin
    int p;
    int acks;
    logic prev_c4;
    reset = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_col = '0; wr_data = '0; swap_req = 1'b0;

    // Reset state
    step(); step(); step();
    check("rst_col_sel", col_sel, 0);
    check("rst_col_en", col_en, 0);
    check("rst_row_n", row_n, 7'h7F);
    check("rst_frame_start", frame_start, 0);
    check("rst_swap_ack", swap_ack, 0);
    reset = 1'b0;
    step();
    check("idle_col_en", col_en, 0);

    // Scan timing: 2 blank + 4 drive per column, 30-cycle frame
    enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      p = k % 30;
      check($sformatf("tim_col_%0d", k), col_sel, p / 6);
      check($sformatf("tim_en_%0d", k), col_en, ((p % 6) >= 2) ? 1 : 0);
      check($sformatf("tim_fs_%0d", k), frame_start, (p == 2) ? 1 : 0);
      check($sformatf("tim_row_%0d", k), row_n, 7'h7F);
    end

    // Data path
    write(3'd2, 7'b1010101);
    pulse_swap();
    wait_ack("dp");
    for (int c = 0; c < 5; c++) begin
      wait_drive(3'(c), $sformatf("dp_c%0d", c));
      check($sformatf("dp_row_c%0d", c), row_n, (c == 2) ? 7'h2A : 7'h7F);
    end

    // Swap timing: request mid-frame, second request while pending
    write(3'd0, 7'h11);
    write(3'd2, 7'h0F);
    wait_drive(3'd1, "st_c1");
    pulse_swap();
    wait_drive(3'd2, "st_c2");
    check("st_front_held", row_n, 7'h2A);
    wait_drive(3'd3, "st_c3");
    pulse_swap();
    acks = 0;
    prev_c4 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (swap_ack) begin
        acks++;
        check("st_ack_col", col_sel, 0);
        check("st_ack_blank", col_en, 0);
        check("st_ack_after_c4", prev_c4, 1);
      end
      prev_c4 = (col_sel == 3'd4) && col_en;
    end
    check("st_ack_count", acks, 1);
    wait_drive(3'd0, "st_n0");
    check("st_row_c0", row_n, 7'h6E);
    wait_drive(3'd2, "st_n2");
    check("st_row_c2", row_n, 7'h70);

    // Boundary collision: write column 0 on the swap edge
    wait_drive(3'd4, "bc_c4");
    step(); step(); step();
    swap_req = 1'b1; wr_en = 1'b1; wr_col = 3'd0; wr_data = 7'h22;
    step();
    swap_req = 1'b0; wr_en = 1'b0;
    check("bc_ack", swap_ack, 1);
    check("bc_ack_col", col_sel, 0);
    wait_drive(3'd0, "bc_c0");
    check("bc_old_data", row_n, 7'h6E);
    pulse_swap();
    wait_ack("bc2");
    wait_drive(3'd0, "bc2_c0");
    check("bc_new_data", row_n, 7'h5D);

    // Illegal write columns are ignored
    write(3'd5, 7'h7F);
    write(3'd7, 7'h7F);
    pulse_swap();
    wait_ack("il");
    for (int c = 0; c < 5; c++) begin
      wait_drive(3'(c), $sformatf("il_c%0d", c));
      check($sformatf("il_row_c%0d", c), row_n,
            (c == 0) ? 7'h5D : (c == 2) ? 7'h70 : 7'h7F);
    end

    // Disable mid-DRIVE with a pending swap, then re-enable
    write(3'd3, 7'h44);
    wait_drive(3'd1, "ds_c1");
    step();
    enable = 1'b0; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("ds_col_en", col_en, 0);
    check("ds_row_n", row_n, 7'h7F);
    check("ds_col_sel", col_sel, 0);
    check("ds_no_ack_yet", swap_ack, 0);
    step();
    check("ds_idle_ack", swap_ack, 1);
    step();
    check("ds_ack_once", swap_ack, 0);
    enable = 1'b1;
    step();
    check("re_blank_col", col_sel, 0);
    check("re_blank_en", col_en, 0);
    step(); step();
    check("re_drive_en", col_en, 1);
    check("re_frame_start", frame_start, 1);
    check("re_row_c0", row_n, 7'h5D);
    wait_drive(3'd3, "re_c3");
    check("re_row_c3", row_n, 7'h3B);

    // Asynchronous reset mid-DRIVE
    step();
    #2 reset = 1'b1;
    #1;
    check("ar_col_en", col_en, 0);
    check("ar_row_n", row_n, 7'h7F);
    check("ar_col_sel", col_sel, 0);
    check("ar_frame_start", frame_start, 0);
    step(); step();
    reset = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    wait_ack("ar");
    wait_drive(3'd0, "ar_c0");
    check("ar_row_c0", row_n, 7'h7F);
    wait_drive(3'd3, "ar_c3");
    check("ar_row_c3", row_n, 7'h7F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
